// File: rtl/fnd_receiver_if.sv
// FND scan bus plus the decoded readback results, grouped for the receiver port list.
// The master drives the active-low digit/segment lines; the slave publishes decoded frames.
interface fnd_receiver_if;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_data;
    logic        frame_valid;
    logic [13:0] value;
    logic [3:0]  digit_1;
    logic [3:0]  digit_10;
    logic [3:0]  digit_100;
    logic [3:0]  digit_1000;
    logic        frame_err;
    logic        link_lost;

    modport master (
        output fnd_digit, fnd_data,
        input  frame_valid, value, digit_1, digit_10, digit_100, digit_1000, frame_err, link_lost
    );

    modport slave (
        input  fnd_digit, fnd_data,
        output frame_valid, value, digit_1, digit_10, digit_100, digit_1000, frame_err, link_lost
    );
endinterface

// File: rtl/fnd_receiver.sv
// Decodes the multiplexed 4-digit FND bus back to BCD digits and a binary value.
// A digit is taken STABLE_CYCLES+3 cycles after the bus settles; no backpressure, frames publish as they complete.
module fnd_receiver #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    fnd_receiver_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] C_STABLE  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_ACCEPT  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] C_TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    r_dig_meta, r_dig_s, r_dig_p;
    logic [7:0]    r_dat_meta, r_dat_s, r_dat_p;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_mask;
    logic [3:0]    r_slot  [4];
    logic [3:0]    r_digit [4];
    logic [13:0]   r_value;
    logic          r_err;
    logic          r_fv;
    logic          r_seen;
    logic [TW-1:0] r_tmo;

    logic          w_same;
    logic          w_accept;
    logic          w_pos_ok;
    logic          w_capture;
    logic          w_complete;
    logic [1:0]    w_idx;
    logic [3:0]    w_code;
    logic [3:0]    w_mask_next;
    logic [3:0]    w_new [4];
    logic [13:0]   w_value;
    logic          w_err;

    function automatic logic [3:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   f_decode = 4'd0;
            7'h79:   f_decode = 4'd1;
            7'h24:   f_decode = 4'd2;
            7'h30:   f_decode = 4'd3;
            7'h19:   f_decode = 4'd4;
            7'h12:   f_decode = 4'd5;
            7'h02:   f_decode = 4'd6;
            7'h78:   f_decode = 4'd7;
            7'h00:   f_decode = 4'd8;
            7'h10:   f_decode = 4'd9;
            7'h7F:   f_decode = 4'hF;
            default: f_decode = 4'hE;
        endcase
    endfunction

    // Blank and invalid codes contribute nothing to the rebuilt value.
    function automatic logic [13:0] f_bin(input logic [3:0] code);
        f_bin = (code <= 4'd9) ? {10'd0, code} : 14'd0;
    endfunction

    // Idle bus is all-ones, so the synchronizers reset to that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dig_meta <= 4'hF;
            r_dig_s    <= 4'hF;
            r_dig_p    <= 4'hF;
            r_dat_meta <= 8'hFF;
            r_dat_s    <= 8'hFF;
            r_dat_p    <= 8'hFF;
        end else begin
            r_dig_meta <= bus.fnd_digit;
            r_dig_s    <= r_dig_meta;
            r_dig_p    <= r_dig_s;
            r_dat_meta <= bus.fnd_data;
            r_dat_s    <= r_dat_meta;
            r_dat_p    <= r_dat_s;
        end
    end

    assign w_same   = (r_dig_s == r_dig_p) && (r_dat_s == r_dat_p);
    assign w_accept = w_same && (r_cnt == C_ACCEPT);
    assign w_code   = f_decode(r_dat_s[6:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_same) begin
            r_cnt <= '0;
        end else if (r_cnt < C_STABLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_pos_ok = 1'b1;
        w_idx    = 2'd0;
        case (r_dig_s)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_pos_ok = 1'b0;
        endcase
    end

    assign w_capture   = w_accept && w_pos_ok;
    assign w_mask_next = r_mask | (4'b0001 << w_idx);
    assign w_complete  = w_capture && (w_mask_next == 4'hF);

    // Slot view including the code being captured this edge, so completion publishes it too.
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_new[i] = (w_capture && (w_idx == 2'(i))) ? w_code : r_slot[i];
            if (w_new[i] == 4'hE) begin
                w_err = 1'b1;
            end
        end
        w_value = f_bin(w_new[3]) * 14'd1000 + f_bin(w_new[2]) * 14'd100
                + f_bin(w_new[1]) * 14'd10   + f_bin(w_new[0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 4'h0;
            end
        end else if (w_capture) begin
            r_slot[w_idx] <= w_code;
            r_mask        <= w_complete ? 4'h0 : w_mask_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fv    <= 1'b0;
            r_value <= 14'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= 4'h0;
            end
        end else begin
            r_fv <= w_complete;
            if (w_complete) begin
                r_value <= w_value;
                r_err   <= w_err;
                for (int i = 0; i < 4; i++) begin
                    r_digit[i] <= w_new[i];
                end
            end
        end
    end

    // Counter restarts after each published frame; r_seen covers the window before the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo  <= '0;
            r_seen <= 1'b0;
        end else if (r_fv) begin
            r_tmo  <= '0;
            r_seen <= 1'b1;
        end else if (r_tmo != C_TMO_MAX) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign bus.frame_valid = r_fv;
    assign bus.value       = r_value;
    assign bus.digit_1     = r_digit[0];
    assign bus.digit_10    = r_digit[1];
    assign bus.digit_100   = r_digit[2];
    assign bus.digit_1000  = r_digit[3];
    assign bus.frame_err   = r_err;
    assign bus.link_lost   = !r_fv && (!r_seen || (r_tmo == C_TMO_MAX));
endmodule

// File: tb/tb_fnd_receiver.sv
// Directed bench for fnd_receiver: drives scan sequences and checks published frames against a scoreboard.
module tb_fnd_receiver;
    localparam int STABLE = 16;
    localparam int TMO    = 1000;
    localparam int DWELL  = 30;

    typedef struct packed {
        logic [13:0] value;
        logic [3:0]  d1000;
        logic [3:0]  d100;
        logic [3:0]  d10;
        logic [3:0]  d1;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests  = 0;
    int   fails  = 0;
    int   frames = 0;
    int   pushed = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    fnd_receiver_if bus();

    fnd_receiver #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v, input logic [3:0] th, hu, te, on, input logic err);
        exp_t e;
        e.value = 14'(v);
        e.d1000 = th;
        e.d100  = hu;
        e.d10   = te;
        e.d1    = on;
        e.err   = err;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic drive(input logic [3:0] dig, input logic [7:0] seg, input int n);
        bus.fnd_digit = dig;
        bus.fnd_data  = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] s1000, s100, s10, s1);
        drive(4'b0111, s1000, DWELL);
        drive(4'b1011, s100,  DWELL);
        drive(4'b1101, s10,   DWELL);
        drive(4'b1110, s1,    DWELL);
    endtask

    task automatic frame_digits(input int th, hu, te, on);
        push_exp(th * 1000 + hu * 100 + te * 10 + on, 4'(th), 4'(hu), 4'(te), 4'(on), 1'b0);
        send_frame(seg_lut[th], seg_lut[hu], seg_lut[te], seg_lut[on]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fv"},    32'(bus.frame_valid), 32'd0);
        check({tag, "_value"}, 32'(bus.value),       32'd0);
        check({tag, "_d1"},    32'(bus.digit_1),     32'd0);
        check({tag, "_d10"},   32'(bus.digit_10),    32'd0);
        check({tag, "_d100"},  32'(bus.digit_100),   32'd0);
        check({tag, "_d1000"}, 32'(bus.digit_1000),  32'd0);
        check({tag, "_err"},   32'(bus.frame_err),   32'd0);
        check({tag, "_lost"},  32'(bus.link_lost),   32'd1);
    endtask

    // Scoreboard side: every published frame must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && bus.frame_valid) begin
            frames++;
            check("frame_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("value",      32'(bus.value),      32'(mon_e.value));
                check("digit_1",    32'(bus.digit_1),    32'(mon_e.d1));
                check("digit_10",   32'(bus.digit_10),   32'(mon_e.d10));
                check("digit_100",  32'(bus.digit_100),  32'(mon_e.d100));
                check("digit_1000", 32'(bus.digit_1000), 32'(mon_e.d1000));
                check("frame_err",  32'(bus.frame_err),  32'(mon_e.err));
                check("lost_on_fv", 32'(bus.link_lost),  32'd0);
            end
        end
    end

    initial begin
        int fcount;
        bit got;
        bus.fnd_digit = 4'hF;
        bus.fnd_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("lost_before_first", 32'(bus.link_lost), 32'd1);

        // 123 scanned twice, then 511 and 0
        frame_digits(0, 1, 2, 3);
        check("lost_after_first", 32'(bus.link_lost), 32'd0);
        frame_digits(0, 1, 2, 3);
        frame_digits(0, 5, 1, 1);
        frame_digits(0, 0, 0, 0);

        // Blank thousands, invalid thousands, and dp-on pattern 0x00 decoding to 8
        push_exp(999, 4'hF, 4'd9, 4'd9, 4'd9, 1'b0);
        send_frame(8'hFF, 8'h90, 8'h90, 8'h90);
        push_exp(999, 4'hE, 4'd9, 4'd9, 4'd9, 1'b1);
        send_frame(8'hFE, 8'h90, 8'h90, 8'h90);
        push_exp(8999, 4'd8, 4'd9, 4'd9, 4'd9, 1'b0);
        send_frame(8'h00, 8'h90, 8'h90, 8'h10);

        // Out-of-order capture
        push_exp(4321, 4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
        drive(4'b1110, seg_lut[1], DWELL);
        drive(4'b1101, seg_lut[2], DWELL);
        drive(4'b0111, seg_lut[4], DWELL);
        drive(4'b1011, seg_lut[3], DWELL);

        // Recapturing a slot overwrites it
        push_exp(8001, 4'd8, 4'd0, 4'd0, 4'd1, 1'b0);
        drive(4'b0111, seg_lut[7], DWELL);
        drive(4'b0111, seg_lut[8], DWELL);
        drive(4'b1011, seg_lut[0], DWELL);
        drive(4'b1101, seg_lut[0], DWELL);
        drive(4'b1110, seg_lut[1], DWELL);

        // Short glitch of 0xF9 inside a 0xC0 dwell on the ones digit
        push_exp(4560, 4'd4, 4'd5, 4'd6, 4'd0, 1'b0);
        drive(4'b0111, seg_lut[4], DWELL);
        drive(4'b1011, seg_lut[5], DWELL);
        drive(4'b1101, seg_lut[6], DWELL);
        drive(4'b1110, 8'hC0, 8);
        drive(4'b1110, 8'hF9, 10);
        drive(4'b1110, 8'hC0, DWELL);
        check("glitch_digit_1", 32'(bus.digit_1), 32'd0);

        // Multi-low and all-off digit patterns are ignored mid-frame
        push_exp(1234, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        drive(4'b0111, seg_lut[1], DWELL);
        drive(4'b1100, seg_lut[4], 60);
        drive(4'b1111, seg_lut[4], 60);
        drive(4'b1011, seg_lut[2], DWELL);
        drive(4'b1101, seg_lut[3], DWELL);
        drive(4'b1110, seg_lut[4], DWELL);

        // Reset mid-frame after two captures; the next frame needs four fresh slots
        drive(4'b0111, seg_lut[9], DWELL);
        drive(4'b1011, seg_lut[9], DWELL);
        drive(4'b1111, 8'hFF, 5);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fcount = frames;
        drive(4'b1101, seg_lut[5], DWELL);
        drive(4'b1110, seg_lut[6], DWELL);
        check("no_frame_half", 32'(frames), 32'(fcount));
        check("lost_after_reset", 32'(bus.link_lost), 32'd1);
        push_exp(3456, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0);
        drive(4'b0111, seg_lut[3], DWELL);
        drive(4'b1011, seg_lut[4], DWELL);

        // Bus frozen at 1110/0xC0 after the last frame; link_lost must rise exactly TMO cycles later
        push_exp(1230, 4'd1, 4'd2, 4'd3, 4'd0, 1'b0);
        drive(4'b0111, seg_lut[1], DWELL);
        drive(4'b1011, seg_lut[2], DWELL);
        drive(4'b1101, seg_lut[3], DWELL);
        bus.fnd_digit = 4'b1110;
        bus.fnd_data  = 8'hC0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.frame_valid) got = 1'b1;
        end
        check("frozen_frame_seen", 32'(got), 32'd1);
        repeat (TMO - 1) @(negedge clk);
        check("lost_at_tmo_minus1", 32'(bus.link_lost), 32'd0);
        @(negedge clk);
        check("lost_at_tmo", 32'(bus.link_lost), 32'd1);
        repeat (50) @(negedge clk);
        check("lost_held", 32'(bus.link_lost), 32'd1);

        // Next completed frame clears link_lost
        frame_digits(2, 0, 2, 4);
        check("lost_recovered", 32'(bus.link_lost), 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drained",  32'(sb.size()), 32'd0);
        check("frame_count", 32'(frames),    32'(pushed));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
